seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Time-multiplexing controller for the two-digit seven-segment PMOD on port 1A. It drives the 8-bit ss_top bus that board tops map onto P1A1..P1A10.
- Shows one byte as two hex digits, scanning them alternately with blanking gaps to prevent ghosting.
- New values arrive over a valid/ready handshake and are applied only at frame boundaries, so a frame never shows half of one value and half of another.

Parameters:
- DIGIT_CYCLES, 12000, clock cycles each digit is lit (1 ms at 12 MHz); must be >= 2.
- BLANK_CYCLES, 120, clock cycles of all-segments-off between digits; must be >= 1.

Ports:
- CLK  input  1  system clock; the only clock.
- RST  input  1  asynchronous, active-high reset.
- enable  input  1  scanning enable; low forces display dark.
- value  input  8  byte to display; [3:0] goes to digit 0, [7:4] to digit 1.
- value_valid  input  1  value is offered this cycle.
- value_ready  output  1  pending buffer empty; a value can be accepted.
- ss_top  output  8  [6:0] segments A..G, active-low (bit0=A); [7] digit select (0 = digit 0, 1 = digit 1).
- frame_done  output  1  one-cycle pulse on the last cycle of each complete frame.

Behaviour:
- Reset (asynchronous):
  - state IDLE, ss_top = 8'h7F, frame_done = 0.
  - display register = 8'h00, pending buffer empty, value_ready = 1.
- Handshake:
  - A value is accepted on a clock edge when value_valid && value_ready; it is written to the pending buffer, which becomes full.
  - value_ready = !pending_full, driven from a register with no combinational path from value_valid.
- Transfer:
  - On every entry to DIG0 (from IDLE or from BLK1), a full pending buffer is copied to the display register and the buffer is emptied.
  - If an accept and a transfer fall on the same edge, the transfer uses the old buffer contents. The buffer was empty in that case, so nothing is copied, and the new value is shown from the next frame.
- States: IDLE, DIG0, BLK0, DIG1, BLK1. A down-counter holding the remaining cycles in the current state is reloaded on every state entry.
- Transitions:
  - IDLE -> DIG0 when enable = 1.
  - DIG0 -> BLK0 -> DIG1 -> BLK1 -> DIG0 when each state's count expires.
  - DIG states last DIGIT_CYCLES; BLK states last BLANK_CYCLES; one frame = 2*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
  - enable = 0 in any non-IDLE state moves to IDLE on the next edge. No partial-frame frame_done is produced.
- ss_top (registered, updates on the same edge as the state change):
  - IDLE: 8'h7F.
  - DIG0: {0, font(display[3:0])}.
  - BLK0: {1, 7'h7F}; select switches while dark.
  - DIG1: {1, font(display[7:4])}.
  - BLK1: {0, 7'h7F}.
- frame_done is high exactly on the final cycle of BLK1.
- RST mid-frame returns everything to reset values immediately and discards any pending value.

Optional Feature:
- Macro SEVEN_SEG_DIM_EN.
- When defined:
  - Adds input brightness[3:0].
  - A 4-bit PWM counter clears on entry to DIG0/DIG1 and increments each cycle while in those states.
  - Segments are lit only while pwm <= brightness, and read 7'h7F otherwise. brightness = 15 gives full on; 0 gives 1/16 duty.
  - The select bit and all timing are unchanged.
- When undefined: no brightness port and digits are lit for the whole DIG period.

Decomposition:
- Package seven_seg_pkg holds:
  - the state encoding constants;
  - SEG_OFF = 7'h7F;
  - the 16-entry active-low hex font (0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E).
- Sub-module seven_seg_hex_decoder: combinational nibble -> 7-bit font lookup, instantiated once and fed by a nibble mux driven by the state.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2, frame 20 cycles):
- Reset, enable = 1, no value offered:
  - ss_top = 8'h40 for 8 cycles, 8'hFF for 2, 8'hC0 for 8, 8'h7F for 2.
  - frame_done pulses every 20 cycles.
- Offer value 8'hA1 mid-DIG1:
  - accepted in one cycle; value_ready drops until the next DIG0 entry;
  - the current frame still shows 00;
  - the next frame shows DIG0 = 8'h79 and DIG1 = 8'h88.
- Offer two values back-to-back (8'h12, then 8'h34) within one frame:
  - the second is stalled with value_ready = 0 until the boundary;
  - the frame after next shows 34.
- Offer a value on the exact BLK1 -> DIG0 edge with the buffer empty:
  - the value is not shown this frame and is shown next frame.
- Drop enable during DIG1, then restore it:
  - ss_top = 8'h7F one cycle after the drop and no frame_done pulse occurs;
  - on restore, DIG0 restarts with a full 8 cycles.
- Assert RST for one cycle mid-BLK0 with a value pending:
  - ss_top = 8'h7F immediately;
  - the display shows 00 after release and value_ready = 1.
- With SEVEN_SEG_DIM_EN defined and brightness = 3:
  - within each DIG period, segments are lit for cycles 0-3 and dark for cycles 4-7.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit seven-segment scanner:
// state encoding, the dark-segment constant and the active-low hex font.
// Optional feature macro used elsewhere in this slice: SEVEN_SEG_DIM_EN.
package seven_seg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIG0 = 3'd1,
        ST_BLK0 = 3'd2,
        ST_DIG1 = 3'd3,
        ST_BLK1 = 3'd4
    } state_t;

    // Segments A..G are active-low, so all-ones is dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Idle output: digit 0 selected, every segment dark.
    localparam logic [7:0] SS_DARK = {1'b0, SEG_OFF};

    // Active-low hex font, bit0 = segment A.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_font(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Two-digit seven-segment scanner for the port 1A PMOD.
// Scans display[3:0] then display[7:4] with dark gaps between digits; new
// values are taken through a one-entry pending buffer and only land in the
// display register on entry to DIG0, so a frame never mixes two values.
// Optional macro SEVEN_SEG_DIM_EN adds a 4-bit brightness input that PWMs
// the segments during each digit period.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | scanning disabled, output dark, digit 0 selected
//   DIG0  | digit 0 lit with display[3:0]
//   BLK0  | all segments dark, select already moved to digit 1
//   DIG1  | digit 1 lit with display[7:4]
//   BLK1  | all segments dark, select back on digit 0; last cycle ends frame
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 12000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic [7:0] value,
    input  logic       value_valid,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [3:0] brightness,
`endif
    output logic       value_ready,
    output logic [7:0] ss_top,
    output logic       frame_done
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter holds cycles remaining after the current one, so a load of N-1
    // gives a state lasting exactly N cycles.
    localparam logic [CNT_W-1:0] DIG_LOAD = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [7:0]       display_q;
    logic [7:0]       display_nxt;
    logic [7:0]       pend_buf;
    logic             pend_full;

    logic             enter_dig0;
    logic             enter_dig1;
    logic             accept;
    logic [3:0]       nibble;
    logic [6:0]       font_seg;
    logic             seg_lit;
    logic [7:0]       ss_top_nxt;

    // State register and remaining-cycle counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and counter reload; dropping enable aborts straight to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if ((state != ST_IDLE) && !enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt = ST_DIG0;
                        cnt_nxt   = DIG_LOAD;
                    end
                end
                ST_DIG0: begin
                    if (cnt == '0) begin
                        state_nxt = ST_BLK0;
                        cnt_nxt   = BLK_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_BLK0: begin
                    if (cnt == '0) begin
                        state_nxt = ST_DIG1;
                        cnt_nxt   = DIG_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_DIG1: begin
                    if (cnt == '0) begin
                        state_nxt = ST_BLK1;
                        cnt_nxt   = BLK_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_BLK1: begin
                    if (cnt == '0) begin
                        state_nxt = ST_DIG0;
                        cnt_nxt   = DIG_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign enter_dig0 = (state_nxt == ST_DIG0) && (state != ST_DIG0);
    assign enter_dig1 = (state_nxt == ST_DIG1) && (state != ST_DIG1);

    // Ready comes straight off the buffer flag, so no path from value_valid.
    assign value_ready = !pend_full;
    assign accept      = value_valid && !pend_full;

    // The display register changes only on DIG0 entry; the output stage sees
    // the post-transfer value so the first lit cycle already shows it.
    assign display_nxt = (enter_dig0 && pend_full) ? pend_buf : display_q;

    // Pending buffer and display register. Accept needs an empty buffer and
    // transfer needs a full one, so the two never act on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_buf  <= 8'h00;
            pend_full <= 1'b0;
            display_q <= 8'h00;
        end else begin
            display_q <= display_nxt;
            if (accept) begin
                pend_buf  <= value;
                pend_full <= 1'b1;
            end else if (enter_dig0 && pend_full) begin
                pend_full <= 1'b0;
            end
        end
    end

    // One shared decoder; the nibble follows the state being entered.
    assign nibble = (state_nxt == ST_DIG1) ? display_nxt[7:4] : display_nxt[3:0];

    seven_seg_hex_decoder u_hex_decoder (
        .nibble (nibble),
        .seg    (font_seg)
    );

`ifdef SEVEN_SEG_DIM_EN
    logic [3:0] pwm;
    logic [3:0] pwm_nxt;

    // PWM phase restarts at every digit entry and runs only while a digit is lit.
    always_comb begin
        pwm_nxt = 4'd0;
        if (enter_dig0 || enter_dig1) begin
            pwm_nxt = 4'd0;
        end else if ((state_nxt == ST_DIG0) || (state_nxt == ST_DIG1)) begin
            pwm_nxt = pwm + 4'd1;
        end
    end

    // PWM phase register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm <= 4'd0;
        end else begin
            pwm <= pwm_nxt;
        end
    end

    assign seg_lit = (pwm_nxt <= brightness);
`else
    assign seg_lit = 1'b1;
`endif

    // Output pattern for the state being entered.
    always_comb begin
        ss_top_nxt = SS_DARK;
        case (state_nxt)
            ST_IDLE: ss_top_nxt = SS_DARK;
            ST_DIG0: ss_top_nxt = {1'b0, seg_lit ? font_seg : SEG_OFF};
            ST_BLK0: ss_top_nxt = {1'b1, SEG_OFF};
            ST_DIG1: ss_top_nxt = {1'b1, seg_lit ? font_seg : SEG_OFF};
            ST_BLK1: ss_top_nxt = {1'b0, SEG_OFF};
            default: ss_top_nxt = SS_DARK;
        endcase
    end

    // Registered output so the pins change on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ss_top <= SS_DARK;
        end else begin
            ss_top <= ss_top_nxt;
        end
    end

    // Last cycle of BLK1; an enable drop leaves BLK1 early so no partial pulse.
    assign frame_done = (state == ST_BLK1) && (cnt == '0);

endmodule

// File: tb/tb_seven_seg_scanner.sv
`timescale 1ns/1ps
module tb_seven_seg_scanner;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] value = 8'h00;
    logic       value_valid = 1'b0;
    logic       value_ready;
    logic [7:0] ss_top;
    logic       frame_done;
    logic [3:0] br = 4'hF;

    int checks = 0;
    int errs   = 0;
    logic exp_ready = 1'b1;

    seven_seg_scanner #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .value       (value),
        .value_valid (value_valid),
`ifdef SEVEN_SEG_DIM_EN
        .brightness  (br),
`endif
        .value_ready (value_ready),
        .ss_top      (ss_top),
        .frame_done  (frame_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected pins at cycle k of a 20-cycle frame (8 lit, 2 dark, 8 lit, 2 dark).
    function automatic logic [7:0] exp_ss(input int k, input logic [7:0] d, input logic [3:0] b);
        if (k < 8)       return {1'b0, (k <= int'(b)) ? font(d[3:0]) : 7'h7F};
        else if (k < 10) return 8'hFF;
        else if (k < 18) return {1'b1, ((k - 10) <= int'(b)) ? font(d[7:4]) : 7'h7F};
        else             return 8'h7F;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Run n cycles of a frame starting at DIG0 entry, showing d, with up to
    // two offers driven right after the checks at cycles k1 and k2.
    task automatic run_frame(input logic [7:0] d, input int n,
                             input int k1, input logic [7:0] v1,
                             input int k2, input logic [7:0] v2);
        logic acc;
        for (int k = 0; k < n; k++) begin
            acc = value_valid && exp_ready;
            if (acc) exp_ready = 1'b0;
            else if (k == 0 && !exp_ready) exp_ready = 1'b1;
            @(negedge CLK);
            chk($sformatf("ss_top d=%h k=%0d", d, k), ss_top, exp_ss(k, d, br));
            chk($sformatf("frame_done k=%0d", k), {7'b0, frame_done}, (k == 19) ? 8'd1 : 8'd0);
            chk($sformatf("value_ready k=%0d", k), {7'b0, value_ready}, {7'b0, exp_ready});
            if (acc) value_valid = 1'b0;
            if (k == k1) begin value = v1; value_valid = 1'b1; end
            if (k == k2) begin value = v2; value_valid = 1'b1; end
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst ss_top", ss_top, 8'h7F);
        chk("rst frame_done", {7'b0, frame_done}, 8'd0);
        chk("rst value_ready", {7'b0, value_ready}, 8'd1);
        RST = 1'b0;
        // Stays idle with enable low
        repeat (3) begin
            @(negedge CLK);
            chk("idle ss_top", ss_top, 8'h7F);
            chk("idle frame_done", {7'b0, frame_done}, 8'd0);
        end
        enable = 1'b1;

        // Default display 00 for two frames
        run_frame(8'h00, 20, -1, 8'h00, -1, 8'h00);
        // Offer A1 mid-DIG1; this frame still shows 00
        run_frame(8'h00, 20, 12, 8'hA1, -1, 8'h00);
        // A1 shown; offer 12 then 34 back-to-back, 34 stalls
        run_frame(8'hA1, 20, 2, 8'h12, 3, 8'h34);
        // 12 shown, 34 accepted at start of this frame
        run_frame(8'h12, 20, -1, 8'h00, -1, 8'h00);
        // 34 shown; offer 5C on the BLK1 -> DIG0 edge
        run_frame(8'h34, 20, 19, 8'h5C, -1, 8'h00);
        run_frame(8'h34, 20, -1, 8'h00, -1, 8'h00);
        run_frame(8'h5C, 20, -1, 8'h00, -1, 8'h00);

        // Drop enable during DIG1
        run_frame(8'h5C, 14, -1, 8'h00, -1, 8'h00);
        enable = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            chk("disabled ss_top", ss_top, 8'h7F);
            chk("disabled frame_done", {7'b0, frame_done}, 8'd0);
        end
        enable = 1'b1;
        run_frame(8'h5C, 20, -1, 8'h00, -1, 8'h00);

        // RST mid-BLK0 with 77 pending
        run_frame(8'h5C, 9, 2, 8'h77, -1, 8'h00);
        RST = 1'b1;
        #1;
        chk("midrst ss_top", ss_top, 8'h7F);
        chk("midrst frame_done", {7'b0, frame_done}, 8'd0);
        chk("midrst value_ready", {7'b0, value_ready}, 8'd1);
        exp_ready = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        run_frame(8'h00, 20, -1, 8'h00, -1, 8'h00);
        run_frame(8'h00, 20, -1, 8'h00, -1, 8'h00);

`ifdef SEVEN_SEG_DIM_EN
        // Dimmed: lit for digit cycles 0-3 only
        br = 4'd3;
        run_frame(8'h00, 20, -1, 8'h00, -1, 8'h00);
        run_frame(8'h00, 20, -1, 8'h00, -1, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
